axil_csr_slave: RTL and testbench
=================================

Name: axil_csr_slave

Overview:
- AXI4-Lite responder (slave end) that terminates AXI4L master traffic into a small control/status register bank.
- The lower half of the bank is read/write control registers, driven out to the datapath. The upper half is read-only status, sampled from datapath inputs.
- Sits between the host/shell AXI4-Lite master and a kernel's configuration logic. One outstanding write and one outstanding read; the two channels are independent.

Parameters:
- AXI4L_ADDR_BITS, 32, address width.
- AXI4L_DATA_BITS, 32, data width; must be 32 or 64.
- N_REGS, 16, total registers; power of two, at least 2. Indices 0..N_REGS/2-1 are control (RW); N_REGS/2..N_REGS-1 are status (RO).
- Derived: BYTES=AXI4L_DATA_BITS/8; OFF=log2(BYTES); IDX=log2(N_REGS).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axil_awaddr  in  AXI4L_ADDR_BITS  write address
- s_axil_awvalid  in  1 / s_axil_awready  out  1
- s_axil_wdata  in  AXI4L_DATA_BITS / s_axil_wstrb  in  BYTES
- s_axil_wvalid  in  1 / s_axil_wready  out  1
- s_axil_bresp  out  2 / s_axil_bvalid  out  1 / s_axil_bready  in  1
- s_axil_araddr  in  AXI4L_ADDR_BITS / s_axil_arvalid  in  1 / s_axil_arready  out  1
- s_axil_rdata  out  AXI4L_DATA_BITS / s_axil_rresp  out  2 / s_axil_rvalid  out  1 / s_axil_rready  in  1
- ctrl_o  out  N_REGS/2*AXI4L_DATA_BITS  control registers, flattened; reg k at bits [k*DATA_BITS +: DATA_BITS]
- ctrl_wr_o  out  1  one-cycle pulse per committed control write
- ctrl_wr_idx_o  out  IDX  index of the written register; valid with ctrl_wr_o
- stat_i  in  N_REGS/2*AXI4L_DATA_BITS  status words, flattened; status reg N_REGS/2+k reads slice k

Behaviour:
- Reset (async, aresetn=0):
  - All control regs 0; bvalid=0, rvalid=0; bresp, rresp, rdata 0; ctrl_wr_o=0.
  - AW/W hold flags cleared; any in-flight transaction is dropped, with no response.
  - awready, wready and arready read 1 from the first cycle after reset deasserts.
- Decode:
  - idx = addr[OFF +: IDX]; addr[OFF-1:0] ignored (unaligned accesses are treated as aligned).
  - Any set bit in addr above OFF+IDX marks the access out-of-range.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are accepted independently, in either order or in the same cycle. The accepted address/data/strb are latched into aw_held / w_held.
  - Commit happens on the edge where both are available: (aw handshake or aw_held) and (w handshake or w_held).
  - On commit: the control reg is updated byte-wise per wstrb (strb bit b enables byte b); bvalid goes to 1; both held flags clear. AW+W in the same cycle gives bvalid in the next cycle.
  - bresp: OKAY (00) for a control reg. SLVERR (10) for a status index or out-of-range address; on SLVERR no register changes and no ctrl_wr_o pulse.
  - wstrb=0 to a control reg: OKAY; no data change; ctrl_wr_o still pulses.
  - ctrl_wr_o/ctrl_wr_idx_o are registered and assert in the cycle after commit, together with the new ctrl_o value.
  - bvalid, bresp are held stable until bready; clear on the handshake edge. A new AW/W is accepted in the next cycle at the earliest.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake edge, rdata is loaded with the control reg, the status slice sampled that cycle, or 0 if out-of-range. rresp = OKAY, or SLVERR if out-of-range. rvalid = 1 in the next cycle (1-cycle latency).
  - rdata, rresp and rvalid are held stable until rready; clear on the handshake edge.
- Simultaneous read and write to the same control reg on the same edge: read returns the pre-write value.
- Read and write channels never stall each other.
- No combinational path from any valid/ready input to any output.

Test Plan:
- Reset -> bvalid=0, rvalid=0, ctrl_o=0; awready=wready=arready=1 in the first cycle after aresetn rises.
- AW=0x08 and W=0xDEADBEEF, strb=0xF, in the same cycle, bready=1 -> bvalid next cycle with bresp=00; ctrl_wr_o pulses with idx=2; ctrl reg 2 = 0xDEADBEEF; read of 0x08 returns 0xDEADBEEF with rresp=00.
- W presented 3 cycles before AW (addr 0x04, data 0x12345678, strb=0x5), reg 1 previously 0xFFFFFFFF -> wready drops after W accepted; bvalid only after AW; reg 1 = 0xFF34FF78.
- Status access, N_REGS=16: stat_i slice 0 = 0xCAFE0001 -> read 0x20 returns 0xCAFE0001 with OKAY. Write to 0x20 -> bresp=10, no ctrl_wr_o pulse, ctrl_o unchanged.
- Out-of-range address 0x40 -> read returns rdata=0, rresp=10; write returns bresp=10.
- Backpressure: bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, rdata and bresp stable; awready=wready=arready=0 throughout. Assert aresetn=0 mid-hold -> bvalid and rvalid drop immediately.

Source files
------------

// File: rtl/axil_csr_slave.sv
// AXI4-Lite slave terminating host traffic into a small CSR bank.
// Lower half of the bank: read/write control registers driven on ctrl_o.
// Upper half: read-only status words sampled from stat_i.
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*        AXI4-Lite write address/data/response channels
//   s_axil_ar*/r*           AXI4-Lite read address/data channels
//   ctrl_o                  flattened control registers (reg k at [k*DW +: DW])
//   ctrl_wr_o/ctrl_wr_idx_o one-cycle pulse + index per committed control write
//   stat_i                  flattened status words (status reg N_REGS/2+k = slice k)
module axil_csr_slave #(
    parameter int unsigned AXI4L_ADDR_BITS = 32,
    parameter int unsigned AXI4L_DATA_BITS = 32,
    parameter int unsigned N_REGS          = 16
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,

    input  logic [AXI4L_ADDR_BITS-1:0]                s_axil_awaddr,
    input  logic                                      s_axil_awvalid,
    output logic                                      s_axil_awready,
    input  logic [AXI4L_DATA_BITS-1:0]                s_axil_wdata,
    input  logic [AXI4L_DATA_BITS/8-1:0]              s_axil_wstrb,
    input  logic                                      s_axil_wvalid,
    output logic                                      s_axil_wready,
    output logic [1:0]                                s_axil_bresp,
    output logic                                      s_axil_bvalid,
    input  logic                                      s_axil_bready,

    input  logic [AXI4L_ADDR_BITS-1:0]                s_axil_araddr,
    input  logic                                      s_axil_arvalid,
    output logic                                      s_axil_arready,
    output logic [AXI4L_DATA_BITS-1:0]                s_axil_rdata,
    output logic [1:0]                                s_axil_rresp,
    output logic                                      s_axil_rvalid,
    input  logic                                      s_axil_rready,

    output logic [N_REGS/2*AXI4L_DATA_BITS-1:0]       ctrl_o,
    output logic                                      ctrl_wr_o,
    output logic [$clog2(N_REGS)-1:0]                 ctrl_wr_idx_o,
    input  logic [N_REGS/2*AXI4L_DATA_BITS-1:0]       stat_i
);

    localparam int unsigned DW     = AXI4L_DATA_BITS;
    localparam int unsigned AW     = AXI4L_ADDR_BITS;
    localparam int unsigned BYTES  = DW / 8;
    localparam int unsigned OFF    = $clog2(BYTES);
    localparam int unsigned IDX    = $clog2(N_REGS);
    localparam int unsigned N_CTRL = N_REGS / 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register index from a byte address; sub-word offset bits are dropped.
    function automatic logic [IDX-1:0] addr_idx(input logic [AW-1:0] a);
        return IDX'(a >> OFF);
    endfunction

    // Any address bit above the register window makes the access out-of-range.
    function automatic logic addr_oor(input logic [AW-1:0] a);
        return (a >> (OFF + IDX)) != '0;
    endfunction

    // State
    logic              aw_held_q;
    logic [AW-1:0]     aw_addr_q;
    logic              w_held_q;
    logic [DW-1:0]     w_data_q;
    logic [BYTES-1:0]  w_strb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [DW-1:0]     rdata_q;
    logic [DW-1:0]     ctrl_q [N_CTRL];
    logic              ctrl_wr_q;
    logic [IDX-1:0]    ctrl_wr_idx_q;

    // Handshake / decode
    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [BYTES-1:0]  wr_strb;
    logic [IDX-1:0]    wr_idx;
    logic              wr_ok;
    logic [IDX-1:0]    rd_idx;
    logic              rd_oor;
    logic [DW-1:0]     rd_word;

    // Ready signals depend only on registered state.
    assign s_axil_awready = !aw_held_q && !bvalid_q;
    assign s_axil_wready  = !w_held_q && !bvalid_q;
    assign s_axil_arready = !rvalid_q;

    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign ctrl_wr_o      = ctrl_wr_q;
    assign ctrl_wr_idx_o  = ctrl_wr_idx_q;

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_flat
        assign ctrl_o[k*DW +: DW] = ctrl_q[k];
    end

    // Write-side combine: a held beat or a live handshake supplies each half.
    always_comb begin
        aw_hs   = s_axil_awvalid && s_axil_awready;
        w_hs    = s_axil_wvalid && s_axil_wready;
        commit  = (aw_hs || aw_held_q) && (w_hs || w_held_q);
        wr_addr = aw_held_q ? aw_addr_q : s_axil_awaddr;
        wr_data = w_held_q ? w_data_q : s_axil_wdata;
        wr_strb = w_held_q ? w_strb_q : s_axil_wstrb;
        wr_idx  = addr_idx(wr_addr);
        // Only in-range control indices (MSB of the index clear) are writable.
        wr_ok   = !addr_oor(wr_addr) && !wr_idx[IDX-1];
    end

    // Read-side decode and data mux.
    always_comb begin
        ar_hs   = s_axil_arvalid && s_axil_arready;
        rd_idx  = addr_idx(s_axil_araddr);
        rd_oor  = addr_oor(s_axil_araddr);
        rd_word = '0;
        if (!rd_oor) begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (rd_idx == IDX'(k)) begin
                    rd_word = ctrl_q[k];
                end
                if (rd_idx == IDX'(k + N_CTRL)) begin
                    rd_word = stat_i[k*DW +: DW];
                end
            end
        end
    end

    // Write channel: hold flags, response and control-write strobe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_held_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            ctrl_wr_q     <= 1'b0;
            ctrl_wr_idx_q <= '0;
        end else begin
            ctrl_wr_q <= 1'b0;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                ctrl_wr_q <= wr_ok;
                if (wr_ok) begin
                    ctrl_wr_idx_q <= wr_idx;
                end
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= s_axil_awaddr;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= s_axil_wdata;
                    w_strb_q <= s_axil_wstrb;
                end
                if (bvalid_q && s_axil_bready) begin
                    bvalid_q <= 1'b0;
                    bresp_q  <= RESP_OKAY;
                end
            end
        end
    end

    // Control register bank with byte-lane write enables.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (wr_idx == IDX'(k)) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wr_strb[b]) begin
                            ctrl_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: capture on AR handshake, hold until R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            rdata_q  <= rd_word;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end
    end

endmodule

// File: tb/tb_axil_csr_slave.sv
// Scoreboard testbench for axil_csr_slave: directed cases then random traffic.
module tb_axil_csr_slave;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned NC = NR / 2;
    localparam int unsigned BY = DW / 8;
    localparam int unsigned IW = $clog2(NR);

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW-1:0]     s_axil_awaddr = '0;
    logic              s_axil_awvalid = 1'b0;
    logic              s_axil_awready;
    logic [DW-1:0]     s_axil_wdata = '0;
    logic [BY-1:0]     s_axil_wstrb = '0;
    logic              s_axil_wvalid = 1'b0;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready = 1'b0;
    logic [AW-1:0]     s_axil_araddr = '0;
    logic              s_axil_arvalid = 1'b0;
    logic              s_axil_arready;
    logic [DW-1:0]     s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready = 1'b0;
    logic [NC*DW-1:0]  ctrl_o;
    logic              ctrl_wr_o;
    logic [IW-1:0]     ctrl_wr_idx_o;
    logic [NC*DW-1:0]  stat_i;

    always #5 aclk = ~aclk;

    axil_csr_slave #(
        .AXI4L_ADDR_BITS(AW),
        .AXI4L_DATA_BITS(DW),
        .N_REGS(NR)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .ctrl_o(ctrl_o),
        .ctrl_wr_o(ctrl_wr_o),
        .ctrl_wr_idx_o(ctrl_wr_idx_o),
        .stat_i(stat_i)
    );

    // Reference model state
    logic [DW-1:0] m_ctrl [NC];
    logic [DW-1:0] m_stat [NC];

    for (genvar k = 0; k < NC; k++) begin : g_stat
        assign stat_i[k*DW +: DW] = m_stat[k];
    end

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic [1:0] exp_b [$];
    rd_exp_t    exp_r [$];
    wr_exp_t    exp_wr [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string why);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    // Address classification from plain arithmetic on the byte address.
    function automatic int unsigned m_idx(input logic [AW-1:0] a);
        return int'((a / BY) % NR);
    endfunction

    function automatic bit m_oor(input logic [AW-1:0] a);
        return a >= AW'(NR * BY);
    endfunction

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] s);
        int unsigned i;
        i = m_idx(a);
        if (m_oor(a) || i >= NC) begin
            exp_b.push_back(2'b10);
        end else begin
            for (int b = 0; b < BY; b++) begin
                if (s[b]) m_ctrl[i][b*8 +: 8] = d[b*8 +: 8];
            end
            exp_b.push_back(2'b00);
            exp_wr.push_back('{idx: IW'(i), data: m_ctrl[i]});
        end
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        int unsigned i;
        i = m_idx(a);
        if (m_oor(a)) exp_r.push_back('{resp: 2'b10, data: '0});
        else if (i < NC) exp_r.push_back('{resp: 2'b00, data: m_ctrl[i]});
        else exp_r.push_back('{resp: 2'b00, data: m_stat[i - NC]});
    endtask

    // Channel drivers: each returns 1ns after its handshake edge.
    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        int c;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axil_awaddr = a;
        s_axil_awvalid = 1'b1;
        c = 0;
        @(negedge aclk);
        while (!s_axil_awready && c < 100) begin @(negedge aclk); c++; end
        if (!s_axil_awready) flag("aw_handshake", "timed out");
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [BY-1:0] s, input int dly);
        int c;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axil_wdata = d;
        s_axil_wstrb = s;
        s_axil_wvalid = 1'b1;
        c = 0;
        @(negedge aclk);
        while (!s_axil_wready && c < 100) begin @(negedge aclk); c++; end
        if (!s_axil_wready) flag("w_handshake", "timed out");
        @(posedge aclk); #1;
        s_axil_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input int dly);
        int c;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axil_araddr = a;
        s_axil_arvalid = 1'b1;
        c = 0;
        @(negedge aclk);
        while (!s_axil_arready && c < 100) begin @(negedge aclk); c++; end
        if (!s_axil_arready) flag("ar_handshake", "timed out");
        @(posedge aclk); #1;
        s_axil_arvalid = 1'b0;
    endtask

    task automatic take_b(input int dly);
        int c;
        c = 0;
        while (!s_axil_bvalid && c < 100) begin @(negedge aclk); c++; end
        if (!s_axil_bvalid) begin
            flag("b_wait", "timed out");
            return;
        end
        #1;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axil_bready = 1'b1;
        @(posedge aclk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic take_r(input int dly);
        int c;
        c = 0;
        while (!s_axil_rvalid && c < 100) begin @(negedge aclk); c++; end
        if (!s_axil_rvalid) begin
            flag("r_wait", "timed out");
            return;
        end
        #1;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axil_rready = 1'b1;
        @(posedge aclk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic check_ctrl_all();
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("ctrl_o[%0d]", k), 64'(ctrl_o[k*DW +: DW]), 64'(m_ctrl[k]));
        end
    endtask

    task automatic write_branch(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] s,
                                input int awd, input int wd, input int bd);
        fork
            send_aw(a, awd);
            send_w(d, s, wd);
        join
        chk("bvalid_latency", 64'(s_axil_bvalid), 64'(1));
        take_b(bd);
    endtask

    task automatic read_branch(input logic [AW-1:0] a, input int ard, input int rd);
        send_ar(a, ard);
        chk("rvalid_latency", 64'(s_axil_rvalid), 64'(1));
        take_r(rd);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] s,
                            input int awd, input int wd, input int bd);
        push_write(a, d, s);
        write_branch(a, d, s, awd, wd, bd);
        check_ctrl_all();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ard, input int rd);
        push_read(a);
        read_branch(a, ard, rd);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a response.
    always @(negedge aclk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (aresetn) begin
            if (s_axil_bvalid && s_axil_bready) begin
                if (exp_b.size() == 0) flag("bresp", "response with nothing expected");
                else chk("bresp", 64'(s_axil_bresp), 64'(exp_b.pop_front()));
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (exp_r.size() == 0) flag("rdata", "response with nothing expected");
                else begin
                    re = exp_r.pop_front();
                    chk("rresp", 64'(s_axil_rresp), 64'(re.resp));
                    chk("rdata", 64'(s_axil_rdata), 64'(re.data));
                end
            end
            if (ctrl_wr_o) begin
                if (exp_wr.size() == 0) flag("ctrl_wr_o", "pulse with no control write");
                else begin
                    we = exp_wr.pop_front();
                    chk("ctrl_wr_idx", 64'(ctrl_wr_idx_o), 64'(we.idx));
                    chk("ctrl_wr_data", 64'(ctrl_o[int'(we.idx)*DW +: DW]), 64'(we.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
        logic [BY-1:0] s;

        for (int k = 0; k < NC; k++) begin
            m_ctrl[k] = '0;
            m_stat[k] = $urandom;
        end

        // Reset values
        #1;
        chk("rst_bvalid", 64'(s_axil_bvalid), 64'(0));
        chk("rst_rvalid", 64'(s_axil_rvalid), 64'(0));
        chk("rst_ctrl_o", 64'(ctrl_o), 64'(0));
        chk("rst_ctrl_wr", 64'(ctrl_wr_o), 64'(0));
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rst_awready", 64'(s_axil_awready), 64'(1));
        chk("rst_wready", 64'(s_axil_wready), 64'(1));
        chk("rst_arready", 64'(s_axil_arready), 64'(1));

        // AW and W together, then read back
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg2_value", 64'(ctrl_o[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
        do_read(32'h08, 0, 0);

        // W three cycles ahead of AW, partial strobe
        do_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        push_write(32'h04, 32'h12345678, 4'h5);
        fork
            begin
                send_w(32'h12345678, 4'h5, 0);
                chk("wready_after_w", 64'(s_axil_wready), 64'(0));
                repeat (2) begin
                    @(negedge aclk);
                    chk("bvalid_before_aw", 64'(s_axil_bvalid), 64'(0));
                end
            end
            send_aw(32'h04, 3);
        join
        chk("bvalid_after_aw", 64'(s_axil_bvalid), 64'(1));
        take_b(1);
        chk("reg1_merge", 64'(ctrl_o[1*DW +: DW]), 64'h0000_0000_FF34_FF78);
        check_ctrl_all();

        // Status access
        m_stat[0] = 32'hCAFE0001;
        do_read(32'h20, 0, 2);
        do_write(32'h20, 32'h55AA55AA, 4'hF, 1, 0, 0);

        // Out-of-range
        do_read(32'h40, 0, 0);
        do_write(32'h40, 32'h11111111, 4'hF, 0, 2, 1);

        // Zero strobe still pulses ctrl_wr_o
        do_write(32'h0C, 32'h99999999, 4'h0, 0, 0, 0);

        // Same-edge read and write of one register returns the old value
        push_read(32'h08);
        push_write(32'h08, 32'h0BADF00D, 4'hF);
        fork
            write_branch(32'h08, 32'h0BADF00D, 4'hF, 0, 0, 0);
            read_branch(32'h08, 0, 0);
        join
        check_ctrl_all();

        // Backpressure hold, then reset mid-hold drops responses
        fork
            begin
                fork
                    send_aw(32'h24, 0);
                    send_w(32'h00000001, 4'hF, 0);
                join
            end
            send_ar(32'h08, 0);
        join
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            chk("hold_bvalid", 64'(s_axil_bvalid), 64'(1));
            chk("hold_bresp", 64'(s_axil_bresp), 64'(2));
            chk("hold_rvalid", 64'(s_axil_rvalid), 64'(1));
            chk("hold_rdata", 64'(s_axil_rdata), 64'h0000_0000_0BAD_F00D);
            chk("hold_awready", 64'(s_axil_awready), 64'(0));
            chk("hold_wready", 64'(s_axil_wready), 64'(0));
            chk("hold_arready", 64'(s_axil_arready), 64'(0));
        end
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_bvalid", 64'(s_axil_bvalid), 64'(0));
        chk("midrst_rvalid", 64'(s_axil_rvalid), 64'(0));
        chk("midrst_ctrl_o", 64'(ctrl_o), 64'(0));
        for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_awready", 64'(s_axil_awready), 64'(1));
        chk("post_rst_wready", 64'(s_axil_wready), 64'(1));
        chk("post_rst_arready", 64'(s_axil_arready), 64'(1));

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) m_stat[$urandom_range(0, NC - 1)] = $urandom;
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0: a = AW'($urandom_range(0, NC * BY - 1));
                    1: a = AW'($urandom_range(NC * BY, NR * BY - 1));
                    2: begin
                        a = $urandom;
                        if (a < AW'(NR * BY)) a = a | AW'(NR * BY);
                    end
                    default: a = AW'($urandom_range(0, NC - 1) * BY);
                endcase
                if (j == 0) ra = a;
            end
            d = $urandom;
            s = BY'($urandom_range(0, (1 << BY) - 1));
            case ($urandom_range(0, 2))
                0: do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3));
                default: begin
                    push_read(ra);
                    push_write(a, d, s);
                    fork
                        write_branch(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
                        read_branch(ra, 0, $urandom_range(0, 3));
                    join
                    check_ctrl_all();
                end
            endcase
        end

        repeat (4) @(posedge aclk);
        #1;
        chk("b_queue_drained", 64'(exp_b.size()), 64'(0));
        chk("r_queue_drained", 64'(exp_r.size()), 64'(0));
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
